// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: NUM_REQ producers share one FIFO write port,
// one owner at a time for bursts of up to MAX_BURST beats, stalled by fifo_full.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_ID   = IW'(NUM_REQ - 1);

  state_t              r_state;
  state_t              w_nextState;
  logic [IW-1:0]       r_rrPtr;
  logic [IW-1:0]       w_nextRrPtr;
  logic [IW-1:0]       r_owner;
  logic [IW-1:0]       w_nextOwner;
  logic [CW-1:0]       r_beatCnt;
  logic [CW-1:0]       w_nextBeatCnt;
  logic [IW-1:0]       w_winner;
  logic [IW-1:0]       w_scanId;
  logic [IW-1:0]       w_ownerInc;
  logic                w_found;
  logic                w_anyReq;
  logic                w_ownerReq;
  logic                w_accept;
  logic                w_lastBeat;
  int                  w_scanIdx;
  logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign w_slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // First set request bit scanning upward from r_rrPtr with modulo wrap.
  always_comb begin
    w_winner  = r_rrPtr;
    w_found   = 1'b0;
    w_scanIdx = 0;
    w_scanId  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scanIdx = int'(r_rrPtr) + k;
      if (w_scanIdx >= NUM_REQ) begin
        w_scanIdx = w_scanIdx - NUM_REQ;
      end
      w_scanId = IW'(w_scanIdx);
      if (!w_found && req[w_scanId]) begin
        w_winner = w_scanId;
        w_found  = 1'b1;
      end
    end
  end

  assign w_anyReq   = |req;
  assign w_ownerReq = req[r_owner];
  assign w_ownerInc = (r_owner == LAST_ID) ? '0 : r_owner + 1'b1;
  assign w_lastBeat = (r_beatCnt == LAST_BEAT);
  assign w_accept   = !rst && (r_state == GRANT) && w_ownerReq && !fifo_full;

  always_comb begin
    req_ack = '0;
    if (w_accept) begin
      req_ack[r_owner] = 1'b1;
    end
  end

  assign fifo_wr_en = w_accept;
  assign fifo_data  = w_accept ? w_slice[r_owner] : '0;
  assign grant_id   = r_owner;
  assign busy       = (r_state == GRANT);

  // Fullness stalls hold the grant without spending burst budget.
  always_comb begin
    w_nextState   = r_state;
    w_nextRrPtr   = r_rrPtr;
    w_nextOwner   = r_owner;
    w_nextBeatCnt = r_beatCnt;
    unique case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_nextState   = GRANT;
          w_nextOwner   = w_winner;
          w_nextBeatCnt = '0;
        end
      end
      GRANT: begin
        if (!w_ownerReq) begin
          w_nextState = IDLE;
          w_nextRrPtr = w_ownerInc;
        end else if (!fifo_full) begin
          if (w_lastBeat) begin
            w_nextState = IDLE;
            w_nextRrPtr = w_ownerInc;
          end
          w_nextBeatCnt = r_beatCnt + 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rrPtr   <= '0;
      r_owner   <= '0;
      r_beatCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_rrPtr   <= w_nextRrPtr;
      r_owner   <= w_nextOwner;
      r_beatCnt <= w_nextBeatCnt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a vector table covers reset, bursts,
// round-robin, stalls and early drops; a hand sequence covers reset mid-burst.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_data;
  logic [1:0]  grant_id;
  logic        busy;

  int checks;
  int errors;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        full;
    logic [3:0]  ack;
    logic        wr;
    logic [7:0]  fdata;
    logic [1:0]  gid;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .DATA_WIDTH(8),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .fifo_full (fifo_full),
    .fifo_wr_en(fifo_wr_en),
    .fifo_data (fifo_data),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic r, input logic [3:0] q, input logic [31:0] d,
                        input logic f, input logic [3:0] a, input logic w,
                        input logic [7:0] fd, input logic [1:0] g, input logic b);
    vec_t v;
    v.rst = r; v.req = q; v.data = d; v.full = f;
    v.ack = a; v.wr = w; v.fdata = fd; v.gid = g; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] q,
                               input logic [31:0] d, input logic f);
    @(negedge clk);
    rst       = r;
    req       = q;
    req_data  = d;
    fifo_full = f;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] a, input logic w,
                          input logic [7:0] fd, input logic [1:0] g, input logic b);
    checkOutput({tag, ".req_ack"},    32'(req_ack),    32'(a));
    checkOutput({tag, ".fifo_wr_en"}, 32'(fifo_wr_en), 32'(w));
    checkOutput({tag, ".fifo_data"},  32'(fifo_data),  32'(fd));
    checkOutput({tag, ".grant_id"},   32'(grant_id),   32'(g));
    checkOutput({tag, ".busy"},       32'(busy),       32'(b));
  endtask

  localparam logic [31:0] DALL = 32'hD3D2_D1D0;

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req       = 4'hF;
    req_data  = DALL;
    fifo_full = 1'b0;

    // Reset with every requester asserted, then first grant to 0
    addVec(1, 4'hF, DALL, 0, 4'b0000, 0, 8'h00, 2'd0, 0);
    addVec(1, 4'hF, DALL, 0, 4'b0000, 0, 8'h00, 2'd0, 0);
    addVec(0, 4'hF, DALL, 0, 4'b0000, 0, 8'h00, 2'd0, 0);

    // Continuous round-robin 0,1,2,3,0 with one bubble between grants
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < ((g == 4) ? 1 : 4); b++) begin
        addVec(0, 4'hF, DALL, 0, 4'(1 << (g % 4)), 1, 8'(8'hD0 + (g % 4)), 2'(g % 4), 1);
      end
      if (g < 4) begin
        addVec(0, 4'hF, DALL, 0, 4'b0000, 0, 8'h00, 2'(g), 0);
      end
    end
    addVec(0, 4'h0, DALL, 0, 4'b0000, 0, 8'h00, 2'd0, 1);
    addVec(0, 4'h0, DALL, 0, 4'b0000, 0, 8'h00, 2'd0, 0);

    // Requester 1 alone: six beats split 4 + bubble + 2
    addVec(0, 4'b0010, 32'h0000_1100, 0, 4'b0000, 0, 8'h00, 2'd0, 0);
    addVec(0, 4'b0010, 32'h0000_1100, 0, 4'b0010, 1, 8'h11, 2'd1, 1);
    addVec(0, 4'b0010, 32'h0000_1200, 0, 4'b0010, 1, 8'h12, 2'd1, 1);
    addVec(0, 4'b0010, 32'h0000_1300, 0, 4'b0010, 1, 8'h13, 2'd1, 1);
    addVec(0, 4'b0010, 32'h0000_1400, 0, 4'b0010, 1, 8'h14, 2'd1, 1);
    addVec(0, 4'b0010, 32'h0000_1500, 0, 4'b0000, 0, 8'h00, 2'd1, 0);
    addVec(0, 4'b0010, 32'h0000_1500, 0, 4'b0010, 1, 8'h15, 2'd1, 1);
    addVec(0, 4'b0010, 32'h0000_1600, 0, 4'b0010, 1, 8'h16, 2'd1, 1);
    addVec(0, 4'b0000, 32'h0000_0000, 0, 4'b0000, 0, 8'h00, 2'd1, 1);
    addVec(0, 4'b0000, 32'h0000_0000, 0, 4'b0000, 0, 8'h00, 2'd1, 0);

    // Requester 2 with a 3-cycle full stall after beat 2
    addVec(0, 4'b0100, 32'h0021_0000, 0, 4'b0000, 0, 8'h00, 2'd1, 0);
    addVec(0, 4'b0100, 32'h0021_0000, 0, 4'b0100, 1, 8'h21, 2'd2, 1);
    addVec(0, 4'b0100, 32'h0022_0000, 0, 4'b0100, 1, 8'h22, 2'd2, 1);
    addVec(0, 4'b0100, 32'h0023_0000, 1, 4'b0000, 0, 8'h00, 2'd2, 1);
    addVec(0, 4'b0100, 32'h0023_0000, 1, 4'b0000, 0, 8'h00, 2'd2, 1);
    addVec(0, 4'b0100, 32'h0023_0000, 1, 4'b0000, 0, 8'h00, 2'd2, 1);
    addVec(0, 4'b0100, 32'h0023_0000, 0, 4'b0100, 1, 8'h23, 2'd2, 1);
    addVec(0, 4'b0100, 32'h0024_0000, 0, 4'b0100, 1, 8'h24, 2'd2, 1);
    addVec(0, 4'b0000, 32'h0000_0000, 0, 4'b0000, 0, 8'h00, 2'd2, 0);

    // Owner 0 drops after 2 beats; requester 3 rose mid-grant and wins next
    addVec(0, 4'b0001, 32'h0000_0031, 0, 4'b0000, 0, 8'h00, 2'd2, 0);
    addVec(0, 4'b1001, 32'h4100_0031, 0, 4'b0001, 1, 8'h31, 2'd0, 1);
    addVec(0, 4'b1001, 32'h4100_0032, 0, 4'b0001, 1, 8'h32, 2'd0, 1);
    addVec(0, 4'b1000, 32'h4100_0000, 0, 4'b0000, 0, 8'h00, 2'd0, 1);
    addVec(0, 4'b1000, 32'h4100_0000, 0, 4'b0000, 0, 8'h00, 2'd0, 0);
    addVec(0, 4'b1000, 32'h4100_0000, 0, 4'b1000, 1, 8'h41, 2'd3, 1);
    addVec(0, 4'b0000, 32'h0000_0000, 0, 4'b0000, 0, 8'h00, 2'd3, 1);
    addVec(0, 4'b0000, 32'h0000_0000, 0, 4'b0000, 0, 8'h00, 2'd3, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].data, vecs[i].full);
      checkAll($sformatf("vec%0d", i), vecs[i].ack, vecs[i].wr, vecs[i].fdata,
               vecs[i].gid, vecs[i].busy);
    end

    // Reset lands on beat 2 of requester 1; the beat is re-presented afterwards
    applyStimulus(0, 4'b0010, 32'h0000_5100, 0);
    checkAll("rstMid.idle", 4'b0000, 0, 8'h00, 2'd3, 0);
    applyStimulus(0, 4'b0010, 32'h0000_5100, 0);
    checkAll("rstMid.beat1", 4'b0010, 1, 8'h51, 2'd1, 1);
    applyStimulus(1, 4'b1010, 32'h0000_5200, 0);
    checkAll("rstMid.rstCycle", 4'b0000, 0, 8'h00, 2'd1, 1);
    applyStimulus(0, 4'b1010, 32'h0000_5200, 0);
    checkAll("rstMid.idleAfter", 4'b0000, 0, 8'h00, 2'd0, 0);
    applyStimulus(0, 4'b1010, 32'h0000_5200, 0);
    checkAll("rstMid.regrant", 4'b0010, 1, 8'h52, 2'd1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
